// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4-lite read arbiter.
// Master IDs double as the value stored in the grant/last registers.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2
   } state_t;

   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin pick.
// req[0] is the IFU, req[1] the LSU; on a tie the master not served last wins.
module rr_arb2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = en && (req != 2'b00);
      gnt_id    = MST_IFU;
      case (req)
         2'b01:   gnt_id = MST_IFU;
         2'b10:   gnt_id = MST_LSU;
         2'b11:   gnt_id = ~last;
         default: gnt_id = MST_IFU;
      endcase
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4-lite read-channel arbiter: one outstanding read, round-robin
// between IFU and LSU, interlocked against the LSU write path.
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter bit          FIRST_GRANT = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [ADDR_W-1:0] mem_araddr,
   output logic              mem_arvalid,
   input  logic              mem_arready,
   input  logic              mem_rvalid,
   output logic              mem_rready,
   input  logic              wr_busy,
   output logic              rd_busy
);

   state_t state, state_nxt;
   logic   gnt;
   logic   last;
   logic   arb_en;
   logic   arb_valid;
   logic   arb_id;
   logic   ar_hs;
   logic   r_hs;

   // wr_busy only gates new grants; an accepted read always runs to completion
   assign arb_en  = (state == IDLE) && !wr_busy;
   assign rd_busy = (state != IDLE);

   rr_arb2 u_rr_arb2 (
      .req       ({lsu_arvalid, ifu_arvalid}),
      .last      (last),
      .en        (arb_en),
      .gnt_valid (arb_valid),
      .gnt_id    (arb_id)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // last is seeded opposite to FIRST_GRANT so the first tie goes to FIRST_GRANT
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt  <= FIRST_GRANT;
         last <= ~FIRST_GRANT;
      end else begin
         if (arb_valid) begin
            gnt <= arb_id;
         end
         if (r_hs) begin
            last <= gnt;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_araddr  = '0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      ifu_arready = 1'b0;
      lsu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      lsu_rvalid  = 1'b0;
      ar_hs       = 1'b0;
      r_hs        = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               state_nxt = AR;
            end
         end
         AR: begin
            mem_araddr  = (gnt == MST_LSU) ? lsu_araddr : ifu_araddr;
            mem_arvalid = (gnt == MST_LSU) ? lsu_arvalid : ifu_arvalid;
            ifu_arready = (gnt == MST_IFU) && mem_arready;
            lsu_arready = (gnt == MST_LSU) && mem_arready;
            ar_hs       = mem_arvalid && mem_arready;
            if (ar_hs) begin
               state_nxt = R;
            end
         end
         R: begin
            ifu_rvalid = (gnt == MST_IFU) && mem_rvalid;
            lsu_rvalid = (gnt == MST_LSU) && mem_rvalid;
            mem_rready = (gnt == MST_LSU) ? lsu_rready : ifu_rready;
            r_hs       = mem_rvalid && mem_rready;
            if (r_hs) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A granted master must hold arvalid until its address is accepted
   a_arvalid_held : assert property (@(posedge clk) disable iff (!rst)
      (state == AR) |-> mem_arvalid);

   a_arready_excl : assert property (@(posedge clk) disable iff (!rst)
      !(ifu_arready && lsu_arready));

   a_rvalid_excl : assert property (@(posedge clk) disable iff (!rst)
      !(ifu_rvalid && lsu_rvalid));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level model plus
// directed scenarios with hand-computed grant orders and cycle counts.
module tb_axi_rd_arbiter;

   localparam int          ADDR_W      = 32;
   localparam bit          FIRST_GRANT = 1'b0;
   localparam logic [31:0] IFU_A       = 32'h8000_0000;
   localparam logic [31:0] LSU_A       = 32'h8000_1000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] ifu_araddr = IFU_A;
   logic              ifu_arvalid = 1'b0;
   logic              ifu_arready;
   logic              ifu_rvalid;
   logic              ifu_rready = 1'b1;
   logic [ADDR_W-1:0] lsu_araddr = LSU_A;
   logic              lsu_arvalid = 1'b0;
   logic              lsu_arready;
   logic              lsu_rvalid;
   logic              lsu_rready = 1'b1;
   logic [ADDR_W-1:0] mem_araddr;
   logic              mem_arvalid;
   logic              mem_arready = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic              mem_rready;
   logic              wr_busy = 1'b0;
   logic              rd_busy;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .FIRST_GRANT(FIRST_GRANT)) dut (
      .clk         (clk),
      .rst         (rst),
      .ifu_araddr  (ifu_araddr),
      .ifu_arvalid (ifu_arvalid),
      .ifu_arready (ifu_arready),
      .ifu_rvalid  (ifu_rvalid),
      .ifu_rready  (ifu_rready),
      .lsu_araddr  (lsu_araddr),
      .lsu_arvalid (lsu_arvalid),
      .lsu_arready (lsu_arready),
      .lsu_rvalid  (lsu_rvalid),
      .lsu_rready  (lsu_rready),
      .mem_araddr  (mem_araddr),
      .mem_arvalid (mem_arvalid),
      .mem_arready (mem_arready),
      .mem_rvalid  (mem_rvalid),
      .mem_rready  (mem_rready),
      .wr_busy     (wr_busy),
      .rd_busy     (rd_busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Masters: each holds arvalid while it has reads pending; a pending read is
   // retired once its address handshake has been seen.
   int pend_ifu = 0;
   int pend_lsu = 0;
   bit ifu_hs = 1'b0;
   bit lsu_hs = 1'b0;

   always @(posedge clk) begin
      #2;
      if (ifu_hs && pend_ifu > 0) pend_ifu--;
      if (lsu_hs && pend_lsu > 0) pend_lsu--;
      ifu_arvalid = (pend_ifu > 0);
      lsu_arvalid = (pend_lsu > 0);
   end

   // Memory: arready after ar_wait cycles of arvalid, rvalid after r_wait data cycles
   int ar_wait = 0;
   int r_wait  = 0;
   int ar_cnt  = 0;
   int r_cnt   = 0;

   always @(posedge clk) begin
      #3;
      if (mem_arvalid) begin
         ar_cnt++;
         mem_arready = (ar_cnt > ar_wait);
      end else begin
         ar_cnt = 0;
         mem_arready = 1'b0;
      end
      if (rd_busy && !mem_arvalid) begin
         r_cnt++;
         mem_rvalid = (r_cnt > r_wait);
      end else begin
         r_cnt = 0;
         mem_rvalid = 1'b0;
      end
   end

   // Transaction-level model: who owns the port, whether its address is done,
   // and who was served last.
   int m_owner = -1;
   bit m_addr_done = 1'b0;
   int m_prev = (FIRST_GRANT == 1'b0) ? 1 : 0;
   int m_log[$];

   always @(posedge clk) begin
      if (!rst) begin
         m_owner     = -1;
         m_addr_done = 1'b0;
         m_prev      = (FIRST_GRANT == 1'b0) ? 1 : 0;
      end else if (m_owner < 0) begin
         if (!wr_busy) begin
            if (ifu_arvalid && lsu_arvalid) m_owner = 1 - m_prev;
            else if (ifu_arvalid)           m_owner = 0;
            else if (lsu_arvalid)           m_owner = 1;
            if (m_owner >= 0) m_log.push_back(m_owner);
         end
      end else if (!m_addr_done) begin
         if (((m_owner == 1) ? lsu_arvalid : ifu_arvalid) && mem_arready) m_addr_done = 1'b1;
      end else if (mem_rvalid && ((m_owner == 1) ? lsu_rready : ifu_rready)) begin
         m_prev      = m_owner;
         m_owner     = -1;
         m_addr_done = 1'b0;
      end
   end

   bit          check_en = 1'b0;
   logic [31:0] dut_log[$];
   int          ifu_beats = 0;
   int          busy_cycles = 0;
   int          lsu_activity = 0;
   bit          in_ar;
   bit          in_r;
   logic [38:0] exp_v;
   logic [38:0] act_v;

   always @(negedge clk) begin
      ifu_hs = ifu_arvalid && ifu_arready;
      lsu_hs = lsu_arvalid && lsu_arready;
      if (mem_arvalid && mem_arready) dut_log.push_back(mem_araddr);
      if (ifu_rvalid && ifu_rready) ifu_beats++;
      if (rd_busy) busy_cycles++;
      if (lsu_arready || lsu_rvalid) lsu_activity++;
      if (check_en) begin
         in_ar = (m_owner >= 0) && !m_addr_done;
         in_r  = (m_owner >= 0) && m_addr_done;
         exp_v = {in_ar && m_owner == 0 && mem_arready,
                  in_r  && m_owner == 0 && mem_rvalid,
                  in_ar && m_owner == 1 && mem_arready,
                  in_r  && m_owner == 1 && mem_rvalid,
                  in_ar && ((m_owner == 1) ? lsu_arvalid : ifu_arvalid),
                  in_r  && ((m_owner == 1) ? lsu_rready : ifu_rready),
                  (m_owner >= 0),
                  in_ar ? ((m_owner == 1) ? lsu_araddr : ifu_araddr) : 32'h0};
         act_v = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                  mem_arvalid, mem_rready, rd_busy, mem_araddr};
         chk("outputs", {25'h0, act_v}, {25'h0, exp_v});
      end
   end

   task automatic wait_quiet(input string name, input int limit);
      int k = 0;
      @(negedge clk);
      while ((pend_ifu > 0 || pend_lsu > 0 || rd_busy) && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_quiet_in_time"}, (k < limit), 1);
   endtask

   task automatic wait_data(input string name, input int limit);
      int k = 0;
      @(negedge clk);
      while (!(rd_busy && !mem_arvalid) && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_data_in_time"}, (k < limit), 1);
   endtask

   task automatic wait_not_busy(input string name, input int limit);
      int k = 0;
      @(negedge clk);
      while (rd_busy && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_idle_in_time"}, (k < limit), 1);
   endtask

   task automatic chk_order(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
      int e[4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk({name, "_dut_count"}, dut_log.size(), n);
      chk({name, "_model_count"}, m_log.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < dut_log.size())
            chk($sformatf("%s_dut_addr%0d", name, i), dut_log[i], (e[i] == 1) ? LSU_A : IFU_A);
         if (i < m_log.size())
            chk($sformatf("%s_model_id%0d", name, i), m_log[i], e[i]);
      end
   endtask

   task automatic clear_logs();
      dut_log.delete();
      m_log.delete();
      ifu_beats    = 0;
      busy_cycles  = 0;
      lsu_activity = 0;
   endtask

   initial begin
      // Reset with both masters requesting
      pend_ifu = 1;
      pend_lsu = 1;
      @(posedge clk); #1;
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_rd_busy", rd_busy, 0);
      chk("reset_mem_arvalid", mem_arvalid, 0);
      chk("reset_arready", {ifu_arready, lsu_arready}, 0);
      chk("reset_rvalid_rready", {ifu_rvalid, lsu_rvalid, mem_rready}, 0);
      chk("reset_mem_araddr", mem_araddr, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      wait_quiet("first_grant", 100);
      chk_order("first_grant", 2, 0, 1, 0, 0);

      // Both request continuously: strict alternation, 3-cycle minimum transactions
      @(posedge clk); #1;
      clear_logs();
      ar_wait = 0; r_wait = 0;
      pend_ifu = 2; pend_lsu = 2;
      wait_quiet("rr", 200);
      chk_order("rr", 4, 0, 1, 0, 1);
      chk("rr_busy_cycles", busy_cycles, 8);

      // IFU alone with slow memory; LSU not ready for data (must not matter)
      @(posedge clk); #1;
      clear_logs();
      ar_wait = 2; r_wait = 3;
      lsu_rready = 1'b0;
      pend_ifu = 1;
      wait_quiet("ifu_only", 100);
      chk_order("ifu_only", 1, 0, 0, 0, 0);
      chk("ifu_only_rbeats", ifu_beats, 1);
      chk("ifu_only_busy_cycles", busy_cycles, 7);
      chk("ifu_only_lsu_quiet", lsu_activity, 0);
      lsu_rready = 1'b1;

      // wr_busy blocks an LSU grant; grant follows one cycle after it falls
      @(posedge clk); #1;
      clear_logs();
      ar_wait = 1; r_wait = 1;
      ifu_rready = 1'b0;
      wr_busy = 1'b1;
      pend_lsu = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("wr_block_%0d", i), rd_busy, 0);
      end
      @(posedge clk); #1;
      wr_busy = 1'b0;
      @(negedge clk);
      chk("wr_release_bubble", rd_busy, 0);
      @(negedge clk);
      chk("wr_release_grant", rd_busy, 1);
      wait_quiet("wr_block", 100);
      chk_order("wr_block", 1, 1, 0, 0, 0);
      ifu_rready = 1'b1;

      // wr_busy rising during R does not abort; blocks the next grant afterwards
      @(posedge clk); #1;
      clear_logs();
      ar_wait = 0; r_wait = 3;
      pend_ifu = 1;
      wait_data("wr_in_r", 50);
      @(posedge clk); #1;
      wr_busy = 1'b1;
      pend_lsu = 1;
      wait_not_busy("wr_in_r", 50);
      chk("wr_in_r_rbeats", ifu_beats, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("wr_in_r_block_%0d", i), rd_busy, 0);
      end
      @(posedge clk); #1;
      wr_busy = 1'b0;
      wait_quiet("wr_in_r", 100);
      chk_order("wr_in_r", 2, 0, 1, 0, 0);

      // IFU served last, then reset while IFU waits in R with rvalid stalled
      @(posedge clk); #1;
      clear_logs();
      ar_wait = 0; r_wait = 0;
      pend_ifu = 1;
      wait_quiet("pre_reset", 50);
      @(posedge clk); #1;
      r_wait = 1;
      ifu_rready = 1'b0;
      pend_ifu = 1;
      wait_data("mid_reset", 50);
      @(negedge clk);
      chk("mid_reset_rvalid_stalled", ifu_rvalid, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_rd_busy", rd_busy, 0);
      chk("mid_reset_mem_rready", mem_rready, 0);
      chk("mid_reset_ifu_rvalid", ifu_rvalid, 0);
      ifu_rready = 1'b1;
      r_wait = 0;
      @(posedge clk); #1;
      clear_logs();
      pend_ifu = 1;
      pend_lsu = 1;
      wait_quiet("post_reset", 100);
      chk_order("post_reset", 2, 0, 1, 0, 0);

      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", n_cmp, n_bad);
      $fatal(1);
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master AXI4-lite read-channel arbiter. It shares the single memory read port between the IFU (instruction fetch) and the LSU (load path).
- It serializes reads with at most one outstanding transaction and uses round-robin fairness.
- It interlocks with the LSU write path through `wr_busy` / `rd_busy`, so reads and writes never overlap at the memory.
- `mem_rdata` and `mem_rresp` fan out to both masters outside this block; only the handshakes are routed here.

Parameters:
- ADDR_W, 32, address width.
- FIRST_GRANT, 0, master favoured first after reset (0 = IFU, 1 = LSU).

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-low reset (0 = reset)
- ifu_araddr  input  ADDR_W  IFU read address
- ifu_arvalid  input  1  IFU read request; held until ifu_arready
- ifu_arready  output  1  IFU address accepted
- ifu_rvalid  output  1  read data valid for IFU
- ifu_rready  input  1  IFU ready for data
- lsu_araddr  input  ADDR_W  LSU read address
- lsu_arvalid  input  1  LSU read request; held until lsu_arready
- lsu_arready  output  1  LSU address accepted
- lsu_rvalid  output  1  read data valid for LSU
- lsu_rready  input  1  LSU ready for data
- mem_araddr  output  ADDR_W  memory read address
- mem_arvalid  output  1  memory read request
- mem_arready  input  1  memory address accepted
- mem_rvalid  input  1  memory data valid
- mem_rready  output  1  arbiter ready for memory data
- wr_busy  input  1  LSU write in flight; blocks new grants
- rd_busy  output  1  read in flight; LSU must not start writes

Behaviour:
- FSM states and transitions:
  - IDLE -> AR when a grant is made.
  - AR -> R when mem_arvalid && mem_arready.
  - R -> IDLE when mem_rvalid && mem_rready.
- Registers: `state`, `gnt` (1 bit: 0 = IFU, 1 = LSU), `last` (last master served).
- Reset (rst == 0 at posedge):
  - state = IDLE, gnt = FIRST_GRANT, last = ~FIRST_GRANT.
  - All outputs 0 while in IDLE.
  - Reset mid-transaction abandons it; the downstream memory is reset on the same rst.
- Grant rule, evaluated in IDLE only, when wr_busy == 0:
  - Only one arvalid high: grant that master.
  - Both high: grant ~last.
  - None high: stay in IDLE.
  - On a grant, register gnt and enter AR next cycle. This gives a 1-cycle arbitration bubble; the AR phase starts the cycle after the request is first seen.
- wr_busy is sampled only in IDLE. It never aborts AR or R.
- In AR:
  - mem_araddr = granted araddr.
  - mem_arvalid = granted arvalid.
  - Granted arready = mem_arready; the other arready = 0.
- In R:
  - Granted rvalid = mem_rvalid; mem_rready = granted rready; the other rvalid = 0.
  - On the completing handshake, last <= gnt.
- Outside their state, mem_arvalid = 0 and mem_rready = 0.
- mem_araddr = 0 when not in AR.
- rd_busy = (state != IDLE). It is combinational from state.
- A nonzero rresp still completes the transaction normally; the master interprets it.
- A master dropping arvalid in AR (protocol violation) is undefined; assertions must flag it.
- Back-to-back: the earliest next grant is the IDLE cycle after R completes, so a minimum transaction is 3 cycles plus memory latency.
- Non-granted masters see arready = 0 for the entire transaction.

Decomposition:
- Package `axi_arb_pkg`:
  - State enum {IDLE, AR, R}.
  - Master IDs MST_IFU = 1'b0, MST_LSU = 1'b1.
- One sub-module `rr_arb2`: combinational two-request round-robin pick. Inputs req[1:0], last, en; outputs gnt_valid, gnt_id.
- The FSM and muxing stay in the top module.

Test Plan:
- Reset with rst = 0 for 2 cycles, both arvalid high -> all outputs 0. First grant after release goes to IFU (FIRST_GRANT = 0).
- IFU alone reads 0x8000_0000, memory arready after 2 cycles, rvalid after 3 -> mem_araddr = 0x8000_0000, ifu_rvalid pulses once, lsu_arready/lsu_rvalid stay 0, rd_busy high from AR entry to R completion.
- Both request continuously for 4 transactions -> grant order IFU, LSU, IFU, LSU, with lsu_araddr = 0x8000_1000 appearing only on LSU turns.
- wr_busy = 1 with lsu_arvalid = 1 for 5 cycles -> no grant and rd_busy = 0; grant the cycle after wr_busy falls.
- wr_busy rises during R -> transaction completes normally, rvalid is delivered, then no new grant until wr_busy falls.
- rst asserted in R mid-transaction -> next cycle state IDLE, mem_rready = 0, ifu_rvalid = 0, last reset so IFU is favoured again.
